// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file write-back front end.
// Default geometry matches the reference reg_file configuration.
package reg_file_pkg;

  localparam int PKG_NUM_REG   = 16;
  localparam int PKG_AW        = $clog2(PKG_NUM_REG);
  localparam int PKG_REG_WIDTH = 32;

  typedef logic [PKG_AW-1:0]        reg_addr_t;
  typedef logic [PKG_REG_WIDTH-1:0] reg_data_t;

  function automatic logic is_zero_reg(input int unsigned addr);
    return addr == 0;
  endfunction

endpackage

// File: rtl/reg_file_wb_ctrl_if.sv
// Write-back source bundle: per-source valid/addr/data with a grant.
// A source holds addr/data stable while valid is high and ready is low.
interface reg_file_wb_ctrl_if
  import reg_file_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int AW        = PKG_AW,
  parameter int REG_WIDTH = PKG_REG_WIDTH
);

  logic [NUM_SRC-1:0]                valid;
  logic [NUM_SRC-1:0][AW-1:0]        addr;
  logic [NUM_SRC-1:0][REG_WIDTH-1:0] data;
  logic [NUM_SRC-1:0]                ready;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/reg_file_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at ptr, wrapping.
// The pointer moves past the winner; it stays put when nobody asks.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Pick the first requester at or after ptr and compute the next ptr.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            ((int'(ptr_q) + k) % NUM_REQ) == i) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_d    = PW'((i + 1) % NUM_REQ);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_file_wb_ctrl.sv
// Write-back front end: arbitrates sources onto the reg_file write port
// and tracks which registers still await a result.
module reg_file_wb_ctrl
  import reg_file_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int NUM_REG   = 16,
  parameter int REG_WIDTH = 32,
  parameter int NUM_RS    = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(NUM_REG)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  reg_file_wb_ctrl_if.slave           wb,
  output logic                        rd_en_o,
  output logic [AW-1:0]               rd_addr_o,
  output logic [REG_WIDTH-1:0]        rd_data_o,
  input  logic                        pend_set_i,
  input  logic [AW-1:0]               pend_addr_i,
  input  logic [NUM_RS-1:0][AW-1:0]   rs_addr_i,
  output logic [NUM_RS-1:0]           rs_pending_o
);

  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   gnt;
  logic                 hs;
  logic [AW-1:0]        sel_addr;
  logic [REG_WIDTH-1:0] sel_data;
  logic                 wr_ok;
  logic                 set_ok;

  logic                 rd_en_q, rd_en_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_REG-1:0]   pend_q, pend_d;

  assign req = wb.valid & {NUM_SRC{rst_ni}};

  rr_arbiter #(
    .NUM_REQ (NUM_SRC)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign wb.ready = gnt;

  // Mux the granted source and decide whether its write is kept.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | wb.addr[i];
        sel_data = sel_data | wb.data[i];
      end
    end
    hs    = |gnt;
    wr_ok = (32'(sel_addr) < NUM_REG) &&
            !((ZERO_REG != 0) && is_zero_reg(32'(sel_addr)));
    rd_en_d   = hs && wr_ok;
    rd_addr_d = rd_en_d ? sel_addr : rd_addr_q;
    rd_data_d = rd_en_d ? sel_data : rd_data_q;
  end

  // Scoreboard next state; a same-edge set overrides the clear.
  always_comb begin
    pend_d = pend_q;
    set_ok = (32'(pend_addr_i) < NUM_REG) &&
             !((ZERO_REG != 0) && is_zero_reg(32'(pend_addr_i)));
    if (rd_en_q) begin
      pend_d[rd_addr_q] = 1'b0;
    end
    if (pend_set_i && set_ok) begin
      pend_d[pend_addr_i] = 1'b1;
    end
  end

  // Output stage and scoreboard flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      pend_q    <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      pend_q    <= pend_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

  // Hazard queries read the flops directly, no bypass.
  always_comb begin
    rs_pending_o = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (32'(rs_addr_i[i]) < NUM_REG) begin
        rs_pending_o[i] = pend_q[rs_addr_i[i]];
      end
    end
  end

endmodule
